// File: rtl/alu_pkg.sv
// Shared operation codes and sequencer state encodings for the ALU execution unit.
package alu_pkg;

    localparam logic [3:0] OpAnd = 4'd0;
    localparam logic [3:0] OpOr  = 4'd1;
    localparam logic [3:0] OpAdd = 4'd2;
    localparam logic [3:0] OpMul = 4'd3;
    localparam logic [3:0] OpSlt = 4'd4;
    localparam logic [3:0] OpSub = 4'd6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } alu_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle after start.
module mul_iter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o
);

    localparam int unsigned    CntW    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

    logic             busy_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_step;

    // Accumulator value after the step in progress; on the last step this is the product.
    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        done_o   = busy_q && (cnt_q == CntLast);
        prod_o   = acc_step;
    end

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit with valid/ready handshakes; single-cycle ops and an iterative multiply.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    alu_state_e       state_q, state_d;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_ill;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q, illegal_q;

    assign accept    = valid_i && (state_q == StIdle);
    assign mul_start = accept && (ALUCtrl_i == OpMul);

    mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .start_i (mul_start),
        .a_i     (src1_i),
        .b_i     (src2_i),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // Single-cycle datapath evaluated on the live inputs; only sampled at accept.
    always_comb begin
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ALUCtrl_i)
            OpAnd: alu_res = src1_i & src2_i;
            OpOr:  alu_res = src1_i | src2_i;
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                          (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                          (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            // Direct signed compare stays correct when the subtraction would overflow.
            OpSlt: alu_res = WIDTH'($signed(src1_i) < $signed(src2_i));
            OpMul: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (valid_i) state_d = (ALUCtrl_i == OpMul) ? StMul : StDone;
            StMul:  if (mul_done) state_d = StDone;
            StDone: if (ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Result registers: loaded at accept, or from the multiplier on its final step.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            result_q   <= alu_res;
            overflow_q <= alu_ovf;
            illegal_q  <= alu_ill;
        end else if ((state_q == StMul) && mul_done) begin
            result_q <= mul_prod;
        end
    end

    // Handshake and status outputs.
    always_comb begin
        ready_o    = (state_q == StIdle);
        valid_o    = (state_q == StDone);
        zero_o     = valid_o && (result_q == '0);
        result_o   = result_q;
        overflow_o = overflow_q;
        illegal_o  = illegal_q;
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, random ops vs. a reference model,
// and hand-written hold, reset-abort and operand-latching sequences.
module tb_alu_exec;

    localparam int unsigned W         = 32;
    localparam int unsigned MulCycles = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i, ready_i;
    logic          ready_o, valid_o;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  src1, src2, result;
    logic          zero, ovf, ill;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec #(
        .WIDTH      (W),
        .MUL_CYCLES (MulCycles)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .ALUCtrl_i  (alu_ctrl),
        .src1_i     (src1),
        .src2_i     (src2),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result),
        .zero_o     (zero),
        .overflow_o (ovf),
        .illegal_o  (ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         ill;
        int           lat;
        int           hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation definitions.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic o, output logic il);
        longint sa, sb, t;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        o  = 1'b0;
        il = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                t = sa + sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd6: begin
                t = sa - sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd3: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
            4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
    endtask

    // Issue one op from IDLE (called #1 after a rising edge) and check the whole transaction.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic eo, input logic ei,
                          input int elat, input int hold, input string name);
        int  lat;
        logic busy_ready;
        logic stable;
        chk({name, "_ready_idle"}, ready_o, 1'b1);
        valid_i  = 1'b1;
        alu_ctrl = op;
        src1     = a;
        src2     = b;
        ready_i  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        // Garbage on the inputs after accept must not reach the result.
        valid_i    = 1'($urandom_range(0, 1));
        alu_ctrl   = 4'($urandom);
        src1       = $urandom;
        src2       = $urandom;
        lat        = 1;
        busy_ready = 1'b0;
        while (!valid_o && lat < 100) begin
            if (ready_o) busy_ready = 1'b1;
            ready_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        ready_i = 1'b0;
        chk({name, "_latency"}, 64'(lat), 64'(elat));
        chk({name, "_ready_busy"}, {busy_ready, ready_o}, 2'b00);
        chk({name, "_result"}, result, er);
        chk({name, "_flags"}, {zero, ovf, ill}, {(er == '0), eo, ei});
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!valid_o || result !== er || {zero, ovf, ill} !== {(er == '0), eo, ei})
                stable = 1'b0;
        end
        if (hold > 0) chk({name, "_hold"}, stable, 1'b1);
        // Handshake edge: a concurrent request must not be taken.
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        alu_ctrl = 4'd2;
        @(posedge clk); #1;
        chk({name, "_release"}, {valid_o, ready_o}, 2'b01);
        valid_i = 1'b0;
        ready_i = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra, rb, rr;
        logic         ro, ri;
        logic         leak;

        vecs.push_back('{4'd2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{4'd6, 32'h5,         32'h5,         32'h0,         1'b0, 1'b0, 1,  1});
        vecs.push_back('{4'd4, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1'b0, 1,  0});
        vecs.push_back('{4'd3, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFD, 1'b0, 1'b0, 33, 0});
        vecs.push_back('{4'd15, 32'h1234,     32'h5678,      32'h0,         1'b0, 1'b1, 1,  5});
        vecs.push_back('{4'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, 1'b0, 1,  0});
        vecs.push_back('{4'd1, 32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011, 1'b0, 1'b0, 1,  2});
        vecs.push_back('{4'd6, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{4'd4, 32'h1,         32'h8000_0000, 32'h0,         1'b0, 1'b0, 1,  0});
        vecs.push_back('{4'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1,  0});
        vecs.push_back('{4'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1,  0});
        vecs.push_back('{4'd5, 32'h1,         32'h1,         32'h0,         1'b0, 1'b1, 1,  0});
        vecs.push_back('{4'd2, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 1,  0});
        vecs.push_back('{4'd3, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0, 1'b0, 33, 1});
        vecs.push_back('{4'd3, 32'd1234,      32'd5678,      32'd7006652,   1'b0, 1'b0, 33, 0});

        rst_n    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        alu_ctrl = 4'd0;
        src1     = '0;
        src2     = '0;
        #12;
        chk("reset_outputs", {valid_o, result, zero, ovf, ill}, 36'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_ready", {ready_o, valid_o}, 2'b10);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].ill,
                   vecs[i].lat, vecs[i].hold, $sformatf("vec%0d", i));

        // Reset during multiply iteration 10 aborts with no result.
        valid_i  = 1'b1;
        alu_ctrl = 4'd3;
        src1     = 32'hDEAD_BEEF;
        src2     = 32'h1234_5678;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mul_abort_in_reset", {valid_o, result, zero, ovf, ill}, 36'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mul_abort_idle", {ready_o, valid_o}, 2'b10);
        leak = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o || !ready_o) leak = 1'b1;
        end
        chk("mul_abort_no_result", leak, 1'b0);
        run_op(4'd2, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0, "post_reset_add");

        // Random operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            if (n % 4 == 0) rb = ra;
            if (n % 5 == 1) ra = {1'b1, 31'($urandom)};
            model(rop, ra, rb, rr, ro, ri);
            run_op(rop, ra, rb, rr, ro, ri, (rop == 4'd3) ? MulCycles + 1 : 1,
                   $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Parameter: MUL_CYCLES, WIDTH, iterations used by the multiply sequencer.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  upstream operation request.
REQ-006 ready_o  output  1  block can accept a request this cycle.
REQ-007 ALUCtrl_i  input  4  operation code: 0 AND, 1 OR, 2 ADD, 3 MUL, 4 SLT, 6 SUB, all others illegal.
REQ-008 src1_i  input  WIDTH  first operand.
REQ-009 src2_i  input  WIDTH  second operand.
REQ-010 valid_o  output  1  result available.
REQ-011 ready_i  input  1  downstream accepts the result.
REQ-012 result_o  output  WIDTH  operation result.
REQ-013 zero_o  output  1  high when result_o == 0.
REQ-014 overflow_o  output  1  signed overflow for ADD/SUB, else 0.
REQ-015 illegal_o  output  1  high when the accepted code was illegal.

Function
REQ-016 The FSM SHALL have states IDLE, MUL, DONE; ready_o SHALL be 1 only in IDLE.
REQ-017 Accept SHALL occur on a rising edge with valid_i=1 and ready_o=1; operands and code SHALL be latched at accept, and later input changes SHALL be ignored.
REQ-018 For AND, OR, ADD, SUB, SLT and illegal codes, the result SHALL be registered at accept and the FSM SHALL go IDLE->DONE, so valid_o rises the cycle after accept (latency 1).
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow_o SHALL be set on signed overflow (operands of equal sign for ADD / differing sign for SUB, and result sign differing from src1).
REQ-020 SLT SHALL produce 1 if src1 < src2 as signed two's-complement, computed correctly even when the subtraction overflows; otherwise 0.
REQ-021 MUL SHALL go IDLE->MUL, perform one shift-add step per cycle for MUL_CYCLES cycles, then go to DONE; valid_o SHALL rise exactly MUL_CYCLES+1 cycles after accept.
REQ-022 The MUL result SHALL be the low WIDTH bits of the product, with overflow_o=0.
REQ-023 An illegal code SHALL give result_o=0, zero_o=1, illegal_o=1, overflow_o=0.
REQ-024 In DONE, valid_o=1 and all result outputs SHALL hold stable until ready_i=1; on that edge the FSM SHALL go to IDLE and valid_o SHALL drop.
REQ-025 No new request SHALL be accepted in the DONE cycle that completes the handshake; the minimum initiation interval is 2 cycles.
REQ-026 zero_o SHALL be derived from the registered result and SHALL be valid whenever valid_o=1.
REQ-027 ready_i SHALL be ignored outside DONE; valid_i SHALL be ignored outside IDLE.

Reset
REQ-028 Asserting rst_i low SHALL immediately force IDLE and clear the multiply iteration counter and accumulator.
REQ-029 During reset, outputs SHALL be: ready_o=1 once released, valid_o=0, result_o=0, zero_o=0, overflow_o=0, illegal_o=0.
REQ-030 Reset during MUL or DONE SHALL abort the operation with no result delivered.

Structure
REQ-031 Operation-code constants (AND, OR, ADD, MUL, SLT, SUB) and FSM state encodings SHALL reside in a shared package alu_pkg, which is also used by the ALU controller.
REQ-032 The iterative multiplier SHALL be a sub-module mul_iter with start/done, an internal counter and an accumulator.

Verification
REQ-033 ADD 0x7FFFFFFF + 1 -> valid_o one cycle after accept; result 0x80000000, overflow_o=1, zero_o=0.
REQ-034 SUB 5 - 5 -> result 0, zero_o=1, overflow_o=0; SLT 0x80000000 vs 1 -> result 1.
REQ-035 MUL 0xFFFFFFFF * 3 -> valid_o exactly 33 cycles after accept; result 0xFFFFFFFD; ready_o=0 throughout.
REQ-036 Illegal code 15 -> illegal_o=1, result 0; ready_i held low 5 cycles -> outputs stable; valid_o drops on the ready_i edge.
REQ-037 rst_i asserted low at MUL iteration 10 -> IDLE, valid_o=0; next ADD 2+3 -> 5 with latency 1.
REQ-038 src1_i/src2_i changed on the cycle after accept -> result reflects the latched operands only.
